// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port indices and default bus widths.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer. A lone
// requester always wins; the pointer moves to the loser on every grant.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       win
);

    logic ptr_q;

    always_comb begin
        if (req[PORT_CPU] && req[PORT_DBG]) begin
            win = ptr_q;
        end else if (req[PORT_DBG]) begin
            win = PORT_DBG;
        end else begin
            win = PORT_CPU;
        end
        gnt = {win, ~win} & {2{|req}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PORT_CPU;
        end else if (advance && (|req)) begin
            ptr_q <= ~win;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one single-cycle
// data-memory interface; reads return data one cycle after the strobe.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              id_q;

    logic [1:0] arb_gnt;
    logic       arb_win;
    logic       take;
    logic       issue;
    logic       resp;
    logic       ack_any;

    // Grants are only offered in IDLE, and never while reset is held.
    assign take = (state_q == StIdle) && !rst;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({dbg_req, cpu_req}),
        .advance (take),
        .gnt     (arb_gnt),
        .win     (arb_win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= PORT_CPU;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cpu_req || dbg_req) begin
                        id_q    <= arb_win;
                        we_q    <= (arb_win == PORT_DBG) ? dbg_we    : cpu_we;
                        addr_q  <= (arb_win == PORT_DBG) ? dbg_addr  : cpu_addr;
                        wdata_q <= (arb_win == PORT_DBG) ? dbg_wdata : cpu_wdata;
                        state_q <= StIssue;
                    end
                end
                StIssue: state_q <= we_q ? StIdle : StResp;
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign issue   = (state_q == StIssue);
    assign resp    = (state_q == StResp);
    assign ack_any = (issue && we_q) || resp;

    assign cpu_gnt   = take && arb_gnt[PORT_CPU];
    assign dbg_gnt   = take && arb_gnt[PORT_DBG];
    assign cpu_ack   = ack_any && (id_q == PORT_CPU);
    assign dbg_ack   = ack_any && (id_q == PORT_DBG);
    assign cpu_rdata = (resp && (id_q == PORT_CPU)) ? mem_rdata : '0;
    assign dbg_rdata = (resp && (id_q == PORT_DBG)) ? mem_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_ack;

    assign mem_en    = issue;
    assign mem_we    = issue && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
